// File: rtl/ifetch_pkg.sv
// Shared constants, fetch-buffer entry type and address alignment helper for the
// instruction-fetch stage.
package ifetch_pkg;

    localparam int DEF_ADDR_W      = 14;
    localparam int DEF_INSTR_W     = 32;
    localparam int IFETCH_PC_STEP  = 4;
    localparam int IFETCH_RESET_PC = 0;

    // Instructions are word aligned, so redirect targets drop their two low bits.
    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0]  addr;
        logic [DEF_INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] align_addr(input logic [31:0] addr);
        return addr & ALIGN_MASK;
    endfunction

endpackage

// File: rtl/ifetch_if.sv
// Fetch-stage bus: redirect input, instruction-ROM port and the decode handshake.
interface ifetch_if
    import ifetch_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int INSTR_W = DEF_INSTR_W
);
    logic               redirect_i;
    logic [ADDR_W-1:0]  redirect_addr_i;
    logic [ADDR_W-1:0]  imem_addr_o;
    logic [INSTR_W-1:0] imem_rdata_i;
    logic               instr_valid_o;
    logic               instr_ready_i;
    logic [INSTR_W-1:0] instr_o;
    logic [ADDR_W-1:0]  addr_o;

    modport master (
        input  redirect_i, redirect_addr_i, imem_rdata_i, instr_ready_i,
        output imem_addr_o, instr_valid_o, instr_o, addr_o
    );

    modport slave (
        output redirect_i, redirect_addr_i, imem_rdata_i, instr_ready_i,
        input  imem_addr_o, instr_valid_o, instr_o, addr_o
    );
endinterface

// File: rtl/ifetch_fifo.sv
// Synchronous fetch buffer of {addr, instr} entries; flush wins over push.
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  entry_t                 wdata,
    output logic [$clog2(DEPTH):0] count,
    output entry_t                 head
);
    localparam int PTR_W = $clog2(DEPTH);

    entry_t             mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;

    assign head = mem_r[rd_ptr_r];

    // Storage, pointers and occupancy; storage is cleared on reset so head reads zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= wr_ptr_r + 1'b1;
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: PC, one ROM read per cycle, credit-limited fetch buffer,
// redirect flush. Define IFETCH_BYPASS_EN to forward a return straight to decode.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int INSTR_W    = DEF_INSTR_W,
    parameter int PC_STEP    = IFETCH_PC_STEP,
    parameter int RESET_PC   = IFETCH_RESET_PC,
    parameter int FIFO_DEPTH = 2
) (
    input  logic      clk_i,
    input  logic      rst_n,
    ifetch_if.master  bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] inflight_addr_r;
    logic              inflight_r;
    logic [CNT_W-1:0]  count_s;
    logic [CNT_W:0]    occupancy_s;
    logic [ADDR_W-1:0] target_s;
    entry_t            head_s;
    entry_t            wdata_s;
    logic              bypass_s;
    logic              valid_s;
    logic              pop_s;
    logic              fifo_pop_s;
    logic              push_s;
    logic              issue_s;

    assign target_s = ADDR_W'(align_addr(32'(bus.redirect_addr_i)));

    // Handshake, kill and credit decisions for the current cycle.
    always_comb begin
        wdata_s = '{addr: inflight_addr_r, instr: bus.imem_rdata_i};
`ifdef IFETCH_BYPASS_EN
        bypass_s = (count_s == '0) && inflight_r;
`else
        bypass_s = 1'b0;
`endif
        valid_s    = (count_s != '0) || bypass_s;
        pop_s      = valid_s && bus.instr_ready_i;
        fifo_pop_s = pop_s && !bypass_s;
        // A redirect kills the returning read; a bypassed return that is taken skips the buffer.
        push_s     = inflight_r && !bus.redirect_i && !(bypass_s && pop_s);
        occupancy_s = {1'b0, count_s} + (CNT_W + 1)'(inflight_r) - (CNT_W + 1)'(pop_s);
        issue_s    = !bus.redirect_i && (occupancy_s < (CNT_W + 1)'(FIFO_DEPTH));
    end

    // PC and in-flight read tracking.
    always_ff @(posedge clk_i) begin
        if (rst_n) begin
            pc_r            <= ADDR_W'(RESET_PC);
            inflight_r      <= 1'b0;
            inflight_addr_r <= '0;
        end else if (bus.redirect_i) begin
            pc_r       <= target_s;
            inflight_r <= 1'b0;
        end else begin
            inflight_r <= issue_s;
            if (issue_s) begin
                inflight_addr_r <= pc_r;
                pc_r            <= pc_r + ADDR_W'(PC_STEP);
            end else begin
                pc_r <= pc_r;
            end
        end
    end

    ifetch_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_n),
        .push  (push_s),
        .pop   (fifo_pop_s),
        .flush (bus.redirect_i),
        .wdata (wdata_s),
        .count (count_s),
        .head  (head_s)
    );

    assign bus.imem_addr_o   = pc_r;
    assign bus.instr_valid_o = valid_s;
    assign bus.instr_o       = bypass_s ? bus.imem_rdata_i : head_s.instr;
    assign bus.addr_o        = bypass_s ? inflight_addr_r  : head_s.addr;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: ROM model, address scoreboard and directed steps.
module tb_ifetch_unit;
    localparam int AW    = 14;
    localparam int IW    = 32;
    localparam int STEP  = 4;
    localparam int DEPTH = 2;
    localparam logic [AW-1:0] RST_PC = 14'h0000;
`ifdef IFETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   pops  = 0;
    int   n;
    logic [AW-1:0] exp_q [$];
    logic [AW-1:0] exp_a;

    logic          pv = 1'b0;
    logic          pr = 1'b0;
    logic          pblock = 1'b1;
    logic [AW-1:0] pa = '0;
    logic [IW-1:0] pi = '0;

    ifetch_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();

    ifetch_unit #(
        .ADDR_W(AW), .INSTR_W(IW), .PC_STEP(STEP), .RESET_PC(0), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_i (clk),
        .rst_n (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] rom(input logic [AW-1:0] a);
        return 32'h0000_0100 + {18'd0, a};
    endfunction

    always @(posedge clk) bus.imem_rdata_i <= rom(bus.imem_addr_o);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_q(input logic [AW-1:0] start);
        exp_q.delete();
        for (int k = 0; k < 64; k++) exp_q.push_back(start + AW'(k * STEP));
    endtask

    task automatic wait_valid(input int max, output int cyc);
        cyc = 0;
        while (bus.instr_valid_o !== 1'b1 && cyc < max) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic do_redirect(input logic [AW-1:0] t);
        bus.redirect_i      = 1'b1;
        bus.redirect_addr_i = t;
        @(posedge clk);
        #1;
        bus.redirect_i = 1'b0;
        load_q(t & 14'h3FFC);
    endtask

    // Scoreboard pop on every handshake, plus stability check under back-pressure.
    always @(negedge clk) begin
        if (!rst) begin
            if (pv && !pr && !pblock) begin
                check("hold_valid", bus.instr_valid_o, 1'b1);
                check("hold_addr", bus.addr_o, pa);
                check("hold_instr", bus.instr_o, pi);
            end
            if (bus.instr_valid_o && bus.instr_ready_i) begin
                pops++;
                total++;
                assert (exp_q.size() != 0) else begin
                    bad++;
                    $error("FAIL sb_underflow observed_addr=%0h expected=queued_entry", bus.addr_o);
                end
                if (exp_q.size() != 0) begin
                    exp_a = exp_q.pop_front();
                    check("sb_addr", bus.addr_o, exp_a);
                    check("sb_instr", bus.instr_o, rom(exp_a));
                end
            end
        end
        pv     = bus.instr_valid_o;
        pr     = bus.instr_ready_i;
        pa     = bus.addr_o;
        pi     = bus.instr_o;
        pblock = bus.redirect_i | rst;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "bench timeout");
    end

    initial begin
        bus.redirect_i      = 1'b0;
        bus.redirect_addr_i = '0;
        bus.instr_ready_i   = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_valid", bus.instr_valid_o, 1'b0);
        check("reset_instr", bus.instr_o, 32'h0);
        check("reset_addr", bus.addr_o, 14'h0);
        check("reset_imem", bus.imem_addr_o, RST_PC);

        // Release with decode stalled: first fetch issues immediately, buffer fills to DEPTH.
        @(posedge clk);
        #1;
        rst = 1'b0;
        load_q(RST_PC);
        @(negedge clk);
        check("rel_imem", bus.imem_addr_o, RST_PC);
        check("rel_valid0", bus.instr_valid_o, 1'b0);
        wait_valid(8, n);
        check("rel_latency", n, LAT);
        check("first_addr", bus.addr_o, RST_PC);
        check("first_instr", bus.instr_o, rom(RST_PC));
        repeat (5) @(negedge clk);
        check("stall_addr", bus.addr_o, RST_PC);
        check("credit_pc", bus.imem_addr_o, RST_PC + AW'(DEPTH * STEP));

        // Release back-pressure: one instruction per cycle, no gap.
        @(posedge clk);
        #1;
        bus.instr_ready_i = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("stream_valid", bus.instr_valid_o, 1'b1);
        end

        // Random back-pressure, scoreboard checks ordering.
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            bus.instr_ready_i = 1'($urandom_range(0, 1));
        end

        // Redirect to an unaligned target while the buffer is full.
        bus.instr_ready_i = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("full_valid", bus.instr_valid_o, 1'b1);
        @(posedge clk);
        #1;
        do_redirect(14'h0203);
        @(negedge clk);
        check("rdr_valid0", bus.instr_valid_o, 1'b0);
        wait_valid(8, n);
        check("rdr_latency", n, LAT);
        check("rdr_addr", bus.addr_o, 14'h0200);
        @(posedge clk);
        #1;
        bus.instr_ready_i = 1'b1;
        repeat (6) @(posedge clk);

        // Back-to-back redirects: the later target wins.
        #1;
        do_redirect(14'h0040);
        do_redirect(14'h0080);
        @(negedge clk);
        check("b2b_valid0", bus.instr_valid_o, 1'b0);
        wait_valid(8, n);
        check("b2b_latency", n, LAT);
        check("b2b_addr", bus.addr_o, 14'h0080);
        repeat (6) @(posedge clk);

        // PC wraps modulo 2^ADDR_W.
        #1;
        do_redirect(14'h3FFC);
        @(negedge clk);
        wait_valid(8, n);
        check("wrap_first", bus.addr_o, 14'h3FFC);
        @(negedge clk);
        check("wrap_valid", bus.instr_valid_o, 1'b1);
        check("wrap_addr", bus.addr_o, 14'h0000);
        repeat (4) @(posedge clk);

        // Reset mid-operation with a full buffer.
        #1;
        bus.instr_ready_i = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("prerst_valid", bus.instr_valid_o, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        load_q(RST_PC);
        @(negedge clk);
        check("rst2_valid0", bus.instr_valid_o, 1'b0);
        check("rst2_imem", bus.imem_addr_o, RST_PC);
        wait_valid(8, n);
        check("rst2_latency", n, LAT);
        check("rst2_addr", bus.addr_o, RST_PC);
        @(posedge clk);
        #1;
        bus.instr_ready_i = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("pops_seen", 32'(pops >= 20), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Parametrised instruction-fetch stage that replaces the single-register fetch.
- Holds the PC and issues one read per cycle to an external synchronous instruction ROM (1-cycle read latency).
- Buffers returned {addr, instr} pairs in a small FIFO and presents them to decode through a valid/ready handshake.
- Supports branch/jump redirect with flush of buffered and in-flight fetches, plus back-pressure from decode.

Parameters:
- ADDR_W, 14, width of PC and ROM address.
- INSTR_W, 32, instruction width.
- PC_STEP, 4, sequential PC increment in bytes.
- RESET_PC, 0, PC value loaded on reset.
- FIFO_DEPTH, 2, fetch-buffer entries; power of two, >=2.

Ports:
- clk_i, in, 1, single clock; all state updates on the rising edge.
- rst_n, in, 1, reset: synchronous, active-high (1 = reset).
- redirect_i, in, 1, taken branch/jump this cycle.
- redirect_addr_i, in, ADDR_W, redirect target.
- imem_addr_o, out, ADDR_W, ROM read address; data returns next cycle.
- imem_rdata_i, in, INSTR_W, ROM read data for the previous cycle's imem_addr_o.
- instr_valid_o, out, 1, instr_o/addr_o hold a valid fetched instruction.
- instr_ready_i, in, 1, decode accepts; transfer occurs when valid && ready.
- instr_o, out, INSTR_W, fetched instruction.
- addr_o, out, ADDR_W, address of instr_o.

Behaviour:
- Reset (rst_n=1 at an edge): pc=RESET_PC, FIFO empty, in-flight flag=0. Outputs: instr_valid_o=0, instr_o=0, addr_o=0. imem_addr_o=pc is combinational. Reset overrides a concurrent redirect_i.
- Issue:
  - Define pop = instr_valid_o && instr_ready_i.
  - issue = !redirect_i && (count + inflight - pop) < FIFO_DEPTH.
  - On issue: inflight<=1, inflight_addr<=pc, pc<=pc+PC_STEP. Otherwise pc holds.
- Return: in the cycle after an issue, imem_rdata_i with inflight_addr is pushed into the FIFO, unless it was killed by a redirect.
- Latency:
  - Issue at cycle N -> FIFO write at edge N+1 -> instr_valid_o=1 in cycle N+2.
  - Steady-state throughput is 1 instr/cycle with ready held high.
- Back-pressure:
  - Output holds stable while valid && !ready.
  - FIFO never overflows; the credit rule guarantees a slot for every in-flight read.
  - Push and pop in the same cycle on a full FIFO is legal.
- Redirect (redirect_i=1 at an edge):
  - pc<=redirect_addr_i with the low 2 bits forced to 0.
  - FIFO flushed (count=0); the in-flight read is discarded (inflight<=0, no push).
  - instr_valid_o=0 in the next cycle.
  - A same-cycle pop is still a valid handshake for the pre-redirect instruction.
  - Earliest post-redirect instruction is visible 2 cycles after the redirect edge.
- PC arithmetic is modulo 2^ADDR_W: pc=2^ADDR_W-4 steps to 0 with no flag.
- Back-to-back redirects: the last one wins; nothing from the earlier target is ever delivered.
- Reset mid-operation drops all buffered and in-flight entries. The first post-reset fetch issues in the first cycle with rst_n=0.

Optional Feature:
- IFETCH_BYPASS_EN defined: when the FIFO is empty and a non-killed return arrives, it drives instr_o/addr_o/instr_valid_o combinationally in that same cycle. If popped, it is not written to the FIFO.
  - Issue-to-valid latency is 1 cycle; after a redirect the first instruction appears 1 cycle after the redirect edge.
- Not defined: all outputs come from FIFO registers; latency as above.

Decomposition:
- Package ifetch_pkg:
  - Default constants RESET_PC and PC_STEP.
  - typedef fetch_entry_t {addr[ADDR_W], instr[INSTR_W]}.
  - Localparam for the alignment mask.
- Sub-module ifetch_fifo: synchronous FIFO of fetch_entry_t.
  - Ports: push, pop, flush, count, head.
  - flush has priority over push.
- PC, credit, and kill logic stay in ifetch_unit.

Test Plan:
- Reset release, ready=1, ROM[i]=i*4+0x100 -> valid from cycle 2; addr_o 0,4,8,... with one instr per cycle; instr_o matches ROM.
- ready=0 for 5 cycles after first valid -> addr_o stays 0, instr_o stable; at most FIFO_DEPTH issues outstanding; after release, addr 4,8 follow with no gap or duplicate.
- redirect_i=1 with addr 0x0203 while FIFO is full -> next cycle valid=0; next delivered addr_o=0x0200 two cycles later; no instruction from 0x0008/0x000C ever delivered.
- Redirects to 0x40 then 0x80 on consecutive cycles -> first delivered addr is 0x80; 0x40 is never delivered.
- Redirect to 0x3FFC, ADDR_W=14 -> delivered addrs 0x3FFC then 0x0000.
- Assert rst_n for 1 cycle while valid=1 with 2 buffered -> valid=0 next cycle; refetch starts at RESET_PC. Repeat with IFETCH_BYPASS_EN defined: valid 1 cycle after issue.
